// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch resolution / prediction unit.
// Funct3 encodings, counter reset value and table index width.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly-not-taken: MSB clear, all lower bits set; a 1-bit counter starts at 1.
  function automatic int unsigned ctr_init(input int unsigned ctr_bits);
    if (ctr_bits <= 1) begin
      return 1;
    end
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned entries);
    if (entries <= 2) begin
      return 1;
    end
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch comparator: evaluates the funct3 condition on rs1/rs2 and flags
// the reserved funct3 encodings as illegal.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit_bht.sv
// Branch resolution plus bimodal/gshare direction predictor with saturating
// counters, optional global history and saturating statistics counters.
module branch_unit_bht
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned GHR_BITS    = 0,
  parameter int unsigned STAT_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 if_pred_taken,
  input  logic                 ex_valid,
  input  logic                 ex_branch,
  input  logic [2:0]           ex_funct3,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_rs1,
  input  logic [XLEN-1:0]      ex_rs2,
  input  logic                 ex_pred_taken,
  output logic                 ex_taken,
  output logic                 ex_mispredict,
  output logic                 ex_illegal,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispred
);

  localparam int unsigned IW = idx_width(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] StatMax = {STAT_BITS{1'b1}};

  logic [CTR_BITS-1:0]  bht_q [BHT_ENTRIES];
  logic [IW-1:0]        ghr_idx;
  logic [IW-1:0]        if_idx;
  logic [IW-1:0]        ex_idx;
  logic                 cmp_taken;
  logic                 cmp_illegal;
  logic                 resolving;
  logic [CTR_BITS-1:0]  ctr_old;
  logic [CTR_BITS-1:0]  ctr_new;
  logic [STAT_BITS-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_BITS-1:0] stat_mispred_q, stat_mispred_d;
  logic                 unused_pc_bits;

  branch_cmp #(
    .XLEN(XLEN)
  ) u_branch_cmp (
    .funct3  (ex_funct3),
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign resolving     = ex_valid & ex_branch & ~cmp_illegal;
  assign ex_illegal    = ex_valid & ex_branch & cmp_illegal;
  assign ex_taken      = resolving & cmp_taken;
  assign ex_mispredict = resolving & (cmp_taken ^ ex_pred_taken);

  // Global history register only exists in gshare configurations.
  if (GHR_BITS == 0) begin : g_bimodal
    assign ghr_idx = '0;
  end else begin : g_gshare
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    if (GHR_BITS == 1) begin : g_one
      assign ghr_d = resolving ? ex_taken : ghr_q;
    end else begin : g_shift
      assign ghr_d = resolving ? {ghr_q[GHR_BITS-2:0], ex_taken} : ghr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ghr_q <= '0;
      end else begin
        ghr_q <= ghr_d;
      end
    end

    assign ghr_idx = IW'(ghr_q);
  end

  assign if_idx = if_pc[IW+1:2] ^ ghr_idx;
  assign ex_idx = ex_pc[IW+1:2] ^ ghr_idx;

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign if_pred_taken = bht_q[if_idx][CTR_BITS-1];

  assign unused_pc_bits = ^{if_pc[XLEN-1:IW+2], if_pc[1:0], ex_pc[XLEN-1:IW+2], ex_pc[1:0]};

  always_comb begin
    ctr_old = bht_q[ex_idx];
    ctr_new = ctr_old;
    if (ex_taken) begin
      if (ctr_old != CtrMax) begin
        ctr_new = ctr_old + 1'b1;
      end
    end else if (ctr_old != '0) begin
      ctr_new = ctr_old - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CtrInit;
      end
    end else if (resolving) begin
      bht_q[ex_idx] <= ctr_new;
    end
  end

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (resolving && (stat_branches_q != StatMax)) begin
      stat_branches_d = stat_branches_q + 1'b1;
    end
    if (ex_mispredict && (stat_mispred_q != StatMax)) begin
      stat_mispred_d = stat_mispred_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Self-checking bench: a bimodal instance and a gshare instance with narrow
// saturating statistics, driven in lockstep and checked against a model.
module tb_branch_unit_bht;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        ex_valid, ex_branch, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2;

  logic        a_pred, a_taken, a_misp, a_ill;
  logic [31:0] a_sb, a_sm;
  logic        b_pred, b_taken, b_misp, b_ill;
  logic [1:0]  b_sb, b_sm;

  always #5 clk = ~clk;

  branch_unit_bht #(
    .XLEN(32), .BHT_ENTRIES(64), .CTR_BITS(2), .GHR_BITS(0), .STAT_BITS(32)
  ) u_dut_bimodal (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(a_pred),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .ex_taken(a_taken), .ex_mispredict(a_misp), .ex_illegal(a_ill),
    .stat_branches(a_sb), .stat_mispred(a_sm)
  );

  branch_unit_bht #(
    .XLEN(32), .BHT_ENTRIES(16), .CTR_BITS(2), .GHR_BITS(4), .STAT_BITS(2)
  ) u_dut_gshare (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(b_pred),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .ex_taken(b_taken), .ex_mispredict(b_misp), .ex_illegal(b_ill),
    .stat_branches(b_sb), .stat_mispred(b_sm)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic        branch;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic        pred;
    logic        exp_taken;
    logic        exp_misp;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    string name;
    logic  taken;
    logic  misp;
    logic  ill;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  // Reference model
  logic [1:0]  m0[64];
  logic [1:0]  m1[16];
  logic [3:0]  mghr;
  logic [31:0] ms0_b, ms0_m;
  logic [1:0]  ms1_b, ms1_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m0[i] = 2'b01;
    for (int i = 0; i < 16; i++) m1[i] = 2'b01;
    mghr  = '0;
    ms0_b = '0;
    ms0_m = '0;
    ms1_b = '0;
    ms1_m = '0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic taken, input logic misp);
    logic [3:0] i1;
    i1 = pc[5:2] ^ mghr;
    m0[pc[7:2]] = sat2(m0[pc[7:2]], taken);
    m1[i1]      = sat2(m1[i1], taken);
    mghr        = {mghr[2:0], taken};
    ms0_b++;
    if (misp) ms0_m++;
    if (ms1_b != 2'b11) ms1_b++;
    if (misp && ms1_m != 2'b11) ms1_m++;
  endtask

  task automatic check_preds(input string tag);
    logic [3:0] i1;
    i1 = if_pc[5:2] ^ mghr;
    chk({tag, " bimodal pred"}, {31'd0, a_pred}, {31'd0, m0[if_pc[7:2]][1]});
    chk({tag, " gshare pred"}, {31'd0, b_pred}, {31'd0, m1[i1][1]});
  endtask

  task automatic check_stats(input string tag);
    chk({tag, " bimodal branches"}, a_sb, ms0_b);
    chk({tag, " bimodal mispred"}, a_sm, ms0_m);
    chk({tag, " gshare branches"}, {30'd0, b_sb}, {30'd0, ms1_b});
    chk({tag, " gshare mispred"}, {30'd0, b_sm}, {30'd0, ms1_m});
  endtask

  // Drive one vector, compare combinational outputs before the edge, update model at the edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    ex_valid      = v.valid;
    ex_branch     = v.branch;
    ex_funct3     = v.f3;
    ex_rs1        = v.rs1;
    ex_rs2        = v.rs2;
    ex_pc         = v.pc;
    ex_pred_taken = v.pred;
    if_pc         = v.pc;
    sb.push_back('{v.name, v.exp_taken, v.exp_misp, v.exp_ill});
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      chk({e.name, " taken A"}, {31'd0, a_taken}, {31'd0, e.taken});
      chk({e.name, " taken B"}, {31'd0, b_taken}, {31'd0, e.taken});
      chk({e.name, " mispredict A"}, {31'd0, a_misp}, {31'd0, e.misp});
      chk({e.name, " mispredict B"}, {31'd0, b_misp}, {31'd0, e.misp});
      chk({e.name, " illegal A"}, {31'd0, a_ill}, {31'd0, e.ill});
      chk({e.name, " illegal B"}, {31'd0, b_ill}, {31'd0, e.ill});
    end
    check_preds({v.name, " pre-edge"});
    @(posedge clk);
    if (v.valid && v.branch && !v.exp_ill) model_update(v.pc, v.exp_taken, v.exp_misp);
    #1;
    ex_valid = 1'b0;
    check_stats(v.name);
    check_preds({v.name, " post-edge"});
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] f3, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] pc, input logic p,
                              input logic et, input logic em);
    vec_t v;
    v = '{n, 1'b1, 1'b1, f3, r1, r2, pc, p, et, em, 1'b0};
    return v;
  endfunction

  initial begin
    vecs[0]  = mk("beq_eq",   F3_BEQ,  32'd5,        32'd5,        32'h100, 1'b0, 1'b1, 1'b1);
    vecs[1]  = mk("blt_neg",  F3_BLT,  32'hFFFFFFFF, 32'd1,        32'h104, 1'b0, 1'b1, 1'b1);
    vecs[2]  = mk("bltu_big", F3_BLTU, 32'hFFFFFFFF, 32'd1,        32'h104, 1'b1, 1'b0, 1'b1);
    vecs[3]  = mk("bne_eq",   F3_BNE,  32'd3,        32'd3,        32'h108, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk("bge_neg",  F3_BGE,  32'd1,        32'hFFFFFFFF, 32'h10C, 1'b1, 1'b1, 1'b0);
    vecs[5]  = mk("bgeu_big", F3_BGEU, 32'd1,        32'hFFFFFFFF, 32'h110, 1'b0, 1'b0, 1'b0);
    vecs[6]  = '{"ill_010", 1'b1, 1'b1, 3'b010, 32'd4, 32'd4, 32'h114, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{"ill_011", 1'b1, 1'b1, 3'b011, 32'd4, 32'd9, 32'h118, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = mk("bne_ne",   F3_BNE,  32'd1,        32'd2,        32'h11C, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk("blt_eq",   F3_BLT,  32'd2,        32'd2,        32'h120, 1'b0, 1'b0, 1'b0);
    vecs[10] = '{"not_branch", 1'b1, 1'b0, F3_BEQ, 32'd5, 32'd5, 32'h124, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"not_valid", 1'b0, 1'b1, 3'b010, 32'd5, 32'd5, 32'h128, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_branch = 1'b0; ex_funct3 = '0; ex_pc = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_pred_taken = 1'b0; if_pc = 32'h100;
    model_reset();
    #3;
    chk("reset pred A", {31'd0, a_pred}, 32'd0);
    chk("reset pred B", {31'd0, b_pred}, 32'd0);
    chk("reset stat_branches", a_sb, 32'd0);
    chk("reset stat_mispred", a_sm, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // BEQ taken with wrong prediction; lookup before the edge sees the old counter
    run_vec(vecs[0]);
    if_pc = 32'h100;
    #1;
    chk("beq learned pred A", {31'd0, a_pred}, 32'd1);
    chk("beq stat_branches", a_sb, 32'd1);
    chk("beq stat_mispred", a_sm, 32'd1);

    for (int i = 1; i < 12; i++) run_vec(vecs[i]);
    chk("gshare stat saturated", {30'd0, b_sb}, 32'd3);

    // Counter saturation at one PC: four taken then one not-taken
    for (int i = 0; i < 4; i++) run_vec(mk("sat_taken", F3_BEQ, 32'd7, 32'd7, 32'h200, 1'b1,
                                           1'b1, 1'b0));
    chk("after 4 taken pred A", {31'd0, a_pred}, 32'd1);
    run_vec(mk("sat_not_taken", F3_BNE, 32'd7, 32'd7, 32'h200, 1'b1, 1'b0, 1'b1));
    chk("after not-taken pred A", {31'd0, a_pred}, 32'd1);
    chk("after not-taken model ctr", {30'd0, m0[0]}, 32'd2);

    // History pattern at one PC; gshare spreads it across entries
    run_vec(mk("hist_t1", F3_BEQ, 32'd1, 32'd1, 32'h300, 1'b0, 1'b1, 1'b1));
    run_vec(mk("hist_n1", F3_BEQ, 32'd1, 32'd2, 32'h300, 1'b0, 1'b0, 1'b0));
    run_vec(mk("hist_t2", F3_BEQ, 32'd1, 32'd1, 32'h300, 1'b0, 1'b1, 1'b1));
    run_vec(mk("hist_n2", F3_BEQ, 32'd1, 32'd2, 32'h300, 1'b0, 1'b0, 1'b0));

    // Reset asserted while a resolving branch is in EX: the update must be dropped
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = F3_BEQ;
    ex_rs1 = 32'd9; ex_rs2 = 32'd9; ex_pc = 32'h300; ex_pred_taken = 1'b0; if_pc = 32'h300;
    @(negedge clk);
    chk("midreset taken before", {31'd0, a_taken}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset stat_branches A", a_sb, 32'd0);
    chk("midreset stat_mispred A", a_sm, 32'd0);
    chk("midreset stat_branches B", {30'd0, b_sb}, 32'd0);
    chk("midreset pred A", {31'd0, a_pred}, 32'd0);
    chk("midreset pred B", {31'd0, b_pred}, 32'd0);
    chk("midreset taken follows", {31'd0, a_taken}, 32'd1);
    @(posedge clk);
    #1;
    model_reset();
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_stats("post-reset");
    check_preds("post-reset");
    run_vec(mk("post_reset_beq", F3_BEQ, 32'd1, 32'd1, 32'h300, 1'b0, 1'b1, 1'b1));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
